// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
// Produces stall/flush controls for PC, IF/ID, ID/EX and EX/MEM from
// load-use hazards, branch mispredictions and a multi-cycle data-memory
// handshake. A two-state memory-wait FSM carries a timeout watchdog, and
// two event counters (stall cycles, accepted mispredictions) feed debug.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_rs1/id_rs2            source registers of the ID instruction
//   id_use_rs1/id_use_rs2    ID instruction actually reads rs1/rs2
//   ex_rd, ex_mem_read       EX destination register, EX is a load
//   ex_is_branch             EX is a branch/jump
//   ex_br_pred/ex_br_taken   predicted and resolved branch outcome
//   dmem_req/dmem_ready      MEM-stage data-memory handshake
//   fStall,dStall,dFlush     PC hold, IF/ID hold, IF/ID clear
//   eStall,eFlush,mStall     ID/EX hold, ID/EX bubble, EX/MEM+MEM/WB hold
//   pc_redirect              PC takes the EX-corrected target
//   mem_err                  sticky memory-timeout flag
//   stall_cnt, flush_cnt     wrapping event counters
module hazard_ctrl #(
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_is_branch,
  input  logic             ex_br_pred,
  input  logic             ex_br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             fStall,
  output logic             dStall,
  output logic             dFlush,
  output logic             eStall,
  output logic             eFlush,
  output logic             mStall,
  output logic             pc_redirect,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [WC_W-1:0]   wait_cnt;
  logic              freeze;
  logic              mispredict;
  logic              load_use;

  always_comb begin
    next_state  = state;
    freeze      = 1'b0;
    mispredict  = ex_is_branch & (ex_br_pred != ex_br_taken);
    load_use    = ex_mem_read & (ex_rd != '0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) |
                   (id_use_rs2 & (id_rs2 == ex_rd)));
    fStall      = 1'b0;
    dStall      = 1'b0;
    dFlush      = 1'b0;
    eStall      = 1'b0;
    eFlush      = 1'b0;
    mStall      = 1'b0;
    pc_redirect = 1'b0;

    unique case (state)
      IDLE: begin
        if (dmem_req && !dmem_ready) begin
          next_state = WAIT;
          freeze     = 1'b1;
        end
      end
      WAIT: begin
        if (dmem_ready) next_state = IDLE;
        else            freeze     = 1'b1;
      end
      default: next_state = IDLE;
    endcase

    // Freeze holds every stage, so a pending mispredict or load-use is
    // simply re-evaluated once memory completes.
    if (!rst) begin
      if (freeze) begin
        fStall = 1'b1;
        dStall = 1'b1;
        eStall = 1'b1;
        mStall = 1'b1;
      end else if (mispredict) begin
        dFlush      = 1'b1;
        eFlush      = 1'b1;
        pc_redirect = 1'b1;
      end else if (load_use) begin
        fStall = 1'b1;
        dStall = 1'b1;
        eFlush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= next_state;
      // Only waiting cycles count toward the timeout; the ready cycle
      // returns to IDLE, which clears the count.
      if (state == WAIT && !dmem_ready) begin
        if (wait_cnt != WC_W'(TIMEOUT)) wait_cnt <= wait_cnt + WC_W'(1);
        if (wait_cnt == WC_W'(TIMEOUT - 1)) mem_err <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (fStall)      stall_cnt <= stall_cnt + CNT_W'(1);
      if (pc_redirect) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (TIMEOUT=4, CNT_W=4). Each row of a
// stimulus table carries the control vector expected for it; the row's
// expectation is queued when driven and popped when the outputs settle.
// Expected counters are derived from the expected control vectors.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_is_branch;
  logic       ex_br_pred, ex_br_taken, dmem_req, dmem_ready;
  logic       fStall, dStall, dFlush, eStall, eFlush, mStall, pc_redirect;
  logic       mem_err;
  logic [3:0] stall_cnt, flush_cnt;
  logic [6:0] ctrl;

  assign ctrl = {fStall, dStall, dFlush, eStall, eFlush, mStall, pc_redirect};

  // {fStall,dStall,dFlush,eStall,eFlush,mStall,pc_redirect}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1100100;
  localparam logic [6:0] MP   = 7'b0010101;
  localparam logic [6:0] FRZ  = 7'b1101010;

  hazard_ctrl #(.REG_W(5), .TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_is_branch(ex_is_branch), .ex_br_pred(ex_br_pred),
    .ex_br_taken(ex_br_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .fStall(fStall), .dStall(dStall), .dFlush(dFlush),
    .eStall(eStall), .eFlush(eFlush), .mStall(mStall),
    .pc_redirect(pc_redirect), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // flags = {mr, br, pred, taken, req, rdy}; uses = {use_rs1, use_rs2}
  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [1:0] uses;
    logic [4:0] rd;
    logic [5:0] flags;
    logic [6:0] exp;
  } stim_t;

  typedef struct {
    string      name;
    logic [6:0] ctrl;
    logic       rst;
  } sb_t;

  sb_t        exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [3:0] exp_stall = '0;
  logic [3:0] exp_flush = '0;

  function automatic stim_t st(input logic r, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [1:0] uses,
                               input logic [4:0] rd, input logic [5:0] flags,
                               input logic [6:0] exp);
    stim_t s;
    s.rst = r; s.rs1 = rs1; s.rs2 = rs2; s.uses = uses;
    s.rd = rd; s.flags = flags; s.exp = exp;
    return s;
  endfunction

  task automatic drive(input string nm, input stim_t s);
    sb_t e;
    rst = s.rst;
    id_rs1 = s.rs1; id_rs2 = s.rs2;
    {id_use_rs1, id_use_rs2} = s.uses;
    ex_rd = s.rd;
    {ex_mem_read, ex_is_branch, ex_br_pred, ex_br_taken, dmem_req, dmem_ready} = s.flags;
    e.name = nm; e.ctrl = s.exp; e.rst = s.rst;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    stim_t tbl[$];
    sb_t   e;
    tbl.push_back(st(1'b1, 5'd5, 5'd5, 2'b11, 5'd5, 6'b111010, NONE));
    tbl.push_back(st(1'b1, 5'd5, 5'd5, 2'b11, 5'd5, 6'b111010, NONE));
    for (int i = 0; i < tbl.size(); i++) begin
      drive("reset", tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (ctrl !== e.ctrl) begin errors++; $display("FAIL %s[%0d] ctrl got %b exp %b", e.name, i, ctrl, e.ctrl); end
      @(posedge clk);
      if (e.rst) begin exp_stall = '0; exp_flush = '0; end
      else begin if (e.ctrl[6]) exp_stall++; if (e.ctrl[0]) exp_flush++; end
      #1;
      checks++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin errors++; $display("FAIL %s[%0d] cnt got %0d/%0d exp %0d/%0d", e.name, i, stall_cnt, flush_cnt, exp_stall, exp_flush); end
    end
    checks++;
    if (mem_err !== 1'b0) begin errors++; $display("FAIL reset mem_err got %b exp 0", mem_err); end
  endtask

  task automatic test_load_use();
    stim_t tbl[$];
    sb_t   e;
    tbl.push_back(st(1'b0, 5'd3, 5'd5, 2'b01, 5'd5, 6'b100000, LU));   // rs2 hazard
    tbl.push_back(st(1'b0, 5'd3, 5'd5, 2'b01, 5'd5, 6'b000000, NONE)); // load moved on
    tbl.push_back(st(1'b0, 5'd9, 5'd2, 2'b10, 5'd9, 6'b100000, LU));   // rs1 hazard
    tbl.push_back(st(1'b0, 5'd9, 5'd2, 2'b11, 5'd4, 6'b100000, NONE)); // no match
    for (int i = 0; i < tbl.size(); i++) begin
      drive("load_use", tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (ctrl !== e.ctrl) begin errors++; $display("FAIL %s[%0d] ctrl got %b exp %b", e.name, i, ctrl, e.ctrl); end
      @(posedge clk);
      if (e.rst) begin exp_stall = '0; exp_flush = '0; end
      else begin if (e.ctrl[6]) exp_stall++; if (e.ctrl[0]) exp_flush++; end
      #1;
      checks++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin errors++; $display("FAIL %s[%0d] cnt got %0d/%0d exp %0d/%0d", e.name, i, stall_cnt, flush_cnt, exp_stall, exp_flush); end
    end
  endtask

  task automatic test_x0_nonuse();
    stim_t tbl[$];
    sb_t   e;
    tbl.push_back(st(1'b0, 5'd0, 5'd0, 2'b11, 5'd0, 6'b100000, NONE)); // x0 destination
    tbl.push_back(st(1'b0, 5'd7, 5'd3, 2'b01, 5'd7, 6'b100000, NONE)); // rs1 not read
    tbl.push_back(st(1'b0, 5'd3, 5'd7, 2'b10, 5'd7, 6'b100000, NONE)); // rs2 not read
    tbl.push_back(st(1'b0, 5'd7, 5'd7, 2'b11, 5'd7, 6'b000000, NONE)); // not a load
    for (int i = 0; i < tbl.size(); i++) begin
      drive("x0_nonuse", tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (ctrl !== e.ctrl) begin errors++; $display("FAIL %s[%0d] ctrl got %b exp %b", e.name, i, ctrl, e.ctrl); end
      @(posedge clk);
      if (e.rst) begin exp_stall = '0; exp_flush = '0; end
      else begin if (e.ctrl[6]) exp_stall++; if (e.ctrl[0]) exp_flush++; end
      #1;
      checks++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin errors++; $display("FAIL %s[%0d] cnt got %0d/%0d exp %0d/%0d", e.name, i, stall_cnt, flush_cnt, exp_stall, exp_flush); end
    end
  endtask

  task automatic test_mispredict();
    stim_t tbl[$];
    sb_t   e;
    tbl.push_back(st(1'b0, 5'd5, 5'd1, 2'b10, 5'd5, 6'b111000, MP));   // overrides load-use
    tbl.push_back(st(1'b0, 5'd1, 5'd1, 2'b00, 5'd2, 6'b010100, MP));   // pred 0, taken 1
    tbl.push_back(st(1'b0, 5'd1, 5'd1, 2'b00, 5'd2, 6'b001000, NONE)); // not a branch
    tbl.push_back(st(1'b0, 5'd1, 5'd1, 2'b00, 5'd2, 6'b011100, NONE)); // correct taken
    tbl.push_back(st(1'b0, 5'd1, 5'd1, 2'b00, 5'd2, 6'b010000, NONE)); // correct not-taken
    for (int i = 0; i < tbl.size(); i++) begin
      drive("mispredict", tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (ctrl !== e.ctrl) begin errors++; $display("FAIL %s[%0d] ctrl got %b exp %b", e.name, i, ctrl, e.ctrl); end
      @(posedge clk);
      if (e.rst) begin exp_stall = '0; exp_flush = '0; end
      else begin if (e.ctrl[6]) exp_stall++; if (e.ctrl[0]) exp_flush++; end
      #1;
      checks++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin errors++; $display("FAIL %s[%0d] cnt got %0d/%0d exp %0d/%0d", e.name, i, stall_cnt, flush_cnt, exp_stall, exp_flush); end
    end
  endtask

  task automatic test_mem_wait();
    stim_t tbl[$];
    sb_t   e;
    logic [3:0] base_stall;
    base_stall = exp_stall;
    for (int k = 0; k < 3; k++)
      tbl.push_back(st(1'b0, 5'd1, 5'd1, 2'b00, 5'd2, 6'b011010, FRZ)); // mispredict held, ready low
    tbl.push_back(st(1'b0, 5'd1, 5'd1, 2'b00, 5'd2, 6'b011011, MP));    // ready rises
    tbl.push_back(st(1'b0, 5'd1, 5'd1, 2'b00, 5'd2, 6'b000000, NONE));  // back in IDLE
    for (int i = 0; i < tbl.size(); i++) begin
      drive("mem_wait", tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (ctrl !== e.ctrl) begin errors++; $display("FAIL %s[%0d] ctrl got %b exp %b", e.name, i, ctrl, e.ctrl); end
      @(posedge clk);
      if (e.rst) begin exp_stall = '0; exp_flush = '0; end
      else begin if (e.ctrl[6]) exp_stall++; if (e.ctrl[0]) exp_flush++; end
      #1;
      checks++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin errors++; $display("FAIL %s[%0d] cnt got %0d/%0d exp %0d/%0d", e.name, i, stall_cnt, flush_cnt, exp_stall, exp_flush); end
    end
    checks++;
    if (stall_cnt !== base_stall + 4'd3) begin errors++; $display("FAIL mem_wait stall_delta got %0d exp %0d", stall_cnt, base_stall + 4'd3); end
    checks++;
    if (mem_err !== 1'b0) begin errors++; $display("FAIL mem_wait mem_err got %b exp 0", mem_err); end
  endtask

  task automatic test_back_to_back();
    stim_t tbl[$];
    sb_t   e;
    tbl.push_back(st(1'b0, 5'd6, 5'd0, 2'b10, 5'd6, 6'b100010, FRZ));  // freeze hides load-use
    tbl.push_back(st(1'b0, 5'd6, 5'd0, 2'b10, 5'd6, 6'b100011, LU));   // ready: load-use appears
    tbl.push_back(st(1'b0, 5'd6, 5'd0, 2'b10, 5'd6, 6'b100011, LU));   // single-cycle access
    tbl.push_back(st(1'b0, 5'd6, 5'd0, 2'b00, 5'd6, 6'b000011, NONE)); // single-cycle, no hazard
    tbl.push_back(st(1'b0, 5'd6, 5'd0, 2'b10, 5'd6, 6'b110100, MP));   // mispredict back to back
    tbl.push_back(st(1'b0, 5'd6, 5'd0, 2'b10, 5'd6, 6'b100000, LU));
    for (int i = 0; i < tbl.size(); i++) begin
      drive("back_to_back", tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (ctrl !== e.ctrl) begin errors++; $display("FAIL %s[%0d] ctrl got %b exp %b", e.name, i, ctrl, e.ctrl); end
      @(posedge clk);
      if (e.rst) begin exp_stall = '0; exp_flush = '0; end
      else begin if (e.ctrl[6]) exp_stall++; if (e.ctrl[0]) exp_flush++; end
      #1;
      checks++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin errors++; $display("FAIL %s[%0d] cnt got %0d/%0d exp %0d/%0d", e.name, i, stall_cnt, flush_cnt, exp_stall, exp_flush); end
    end
  endtask

  task automatic test_timeout();
    stim_t tbl[$];
    sb_t   e;
    logic  exp_err;
    for (int k = 0; k < 8; k++)
      tbl.push_back(st(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 6'b000010, FRZ)); // ready never comes
    tbl.push_back(st(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 6'b000010, NONE));  // reset aborts WAIT
    tbl.push_back(st(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 6'b000000, NONE));  // IDLE: no freeze
    for (int i = 0; i < tbl.size(); i++) begin
      drive("timeout", tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (ctrl !== e.ctrl) begin errors++; $display("FAIL %s[%0d] ctrl got %b exp %b", e.name, i, ctrl, e.ctrl); end
      @(posedge clk);
      if (e.rst) begin exp_stall = '0; exp_flush = '0; end
      else begin if (e.ctrl[6]) exp_stall++; if (e.ctrl[0]) exp_flush++; end
      #1;
      // Row 0 is the IDLE cycle; after row i there have been i WAIT cycles.
      exp_err = (i >= 4 && i < 8);
      checks++;
      if (mem_err !== exp_err) begin errors++; $display("FAIL %s[%0d] mem_err got %b exp %b", e.name, i, mem_err, exp_err); end
      checks++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin errors++; $display("FAIL %s[%0d] cnt got %0d/%0d exp %0d/%0d", e.name, i, stall_cnt, flush_cnt, exp_stall, exp_flush); end
    end
  endtask

  task automatic test_wrap();
    stim_t tbl[$];
    sb_t   e;
    tbl.push_back(st(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 6'b000000, NONE));
    for (int k = 0; k < 16; k++)
      tbl.push_back(st(1'b0, 5'd8, 5'd0, 2'b10, 5'd8, 6'b100000, LU));
    for (int i = 0; i < tbl.size(); i++) begin
      drive("wrap", tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (ctrl !== e.ctrl) begin errors++; $display("FAIL %s[%0d] ctrl got %b exp %b", e.name, i, ctrl, e.ctrl); end
      @(posedge clk);
      if (e.rst) begin exp_stall = '0; exp_flush = '0; end
      else begin if (e.ctrl[6]) exp_stall++; if (e.ctrl[0]) exp_flush++; end
      #1;
      checks++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin errors++; $display("FAIL %s[%0d] cnt got %0d/%0d exp %0d/%0d", e.name, i, stall_cnt, flush_cnt, exp_stall, exp_flush); end
    end
    checks++;
    if (stall_cnt !== 4'd0) begin errors++; $display("FAIL wrap stall_cnt got %0d exp 0", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0_nonuse();
    test_mispredict();
    test_mem_wait();
    test_back_to_back();
    test_timeout();
    test_wrap();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard leftover got %0d exp 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
